// File: rtl/load_ext_pkg.sv
// Shared definitions for the MEM->WB load extender: access sizes, skid states and
// the misalignment rule also used by the MEM exception logic.
package load_ext_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // The offset is always passed as 3 bits; 32-bit callers zero-extend it.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        return (size == SZ_H && off[0]) ||
               (size == SZ_W && off[1:0] != 2'b00) ||
               (size == SZ_D && off != 3'b000);
    endfunction

    function automatic logic [2:0] align_offset(input logic [1:0] size, input logic [2:0] off);
        logic [2:0] res;
        case (size)
            SZ_B:    res = off;
            SZ_H:    res = {off[2:1], 1'b0};
            SZ_W:    res = {off[2], 2'b00};
            default: res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_ext_lane.sv
// Combinational lane select and zero/sign extension of one load result.
// Macro LOAD_EXT_MISALIGN_TRAP_EN turns misaligned offsets into an error result.
module load_ext_lane
    import load_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFF_W = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    logic [1:0]        effSize;
    logic [2:0]        off3;
    logic [2:0]        selOff;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] ext;
    logic              signBit;
    logic              fill;
    logic              err;
    int                fieldBits;

    always_comb begin
        effSize = size_i;
        if (DATA_W == 32 && size_i == SZ_D) begin
            effSize = SZ_W;
        end
        off3 = 3'(off_i);
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
        err    = misaligned(effSize, off3);
        selOff = off3;
`else
        err    = 1'b0;
        selOff = align_offset(effSize, off3);
`endif
        lane = data_i >> {selOff, 3'b000};

        fieldBits = DATA_W;
        signBit   = lane[DATA_W-1];
        case (effSize)
            SZ_B: begin fieldBits = 8;  signBit = lane[7];  end
            SZ_H: begin fieldBits = 16; signBit = lane[15]; end
            SZ_W: begin fieldBits = 32; signBit = lane[31]; end
            default: ;
        endcase

        // A full-width field leaves no upper bits, so sext has no effect there.
        fill = sext_i & signBit;
        ext  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ext[i] = (i < fieldBits) ? lane[i] : fill;
        end

        data_o = err ? '0 : ext;
        err_o  = err;
    end

endmodule

// File: rtl/load_ext_pipe.sv
// Registered load extender with a 2-entry skid buffer so WB stalls never reach MEM
// combinationally. Macro LOAD_EXT_MISALIGN_TRAP_EN enables the misalignment trap.
module load_ext_pipe
    import load_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFF_W = $clog2(DATA_W/8)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [OFF_W-1:0]  in_off_i,
    input  logic [1:0]        in_size_i,
    input  logic              in_sext_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_err_o
);

    skid_state_e       state_q, state_d;
    logic              inReady_q;
    logic [DATA_W-1:0] mainData_q, skidData_q;
    logic              mainErr_q, skidErr_q;
    logic [DATA_W-1:0] laneData;
    logic              laneErr;
    logic              accept, pop;
    logic              loadMain, mainFromSkid, loadSkid;

    load_ext_lane #(.DATA_W(DATA_W)) u_lane (
        .data_i (in_data_i),
        .off_i  (in_off_i),
        .size_i (in_size_i),
        .sext_i (in_sext_i),
        .data_o (laneData),
        .err_o  (laneErr)
    );

    assign accept      = in_valid_i && inReady_q;
    assign out_valid_o = (state_q != SKID_EMPTY);
    assign pop         = out_valid_o && out_ready_i;
    assign in_ready_o  = inReady_q;
    assign out_data_o  = mainData_q;
    assign out_err_o   = mainErr_q;

    always_comb begin
        state_d      = state_q;
        loadMain     = 1'b0;
        mainFromSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d  = SKID_ONE;
                    loadMain = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && !pop) begin
                    state_d  = SKID_TWO;
                    loadSkid = 1'b1;
                end else if (pop && !accept) begin
                    state_d = SKID_EMPTY;
                end else if (accept && pop) begin
                    loadMain = 1'b1;
                end
            end
            SKID_TWO: begin
                if (pop) begin
                    state_d      = SKID_ONE;
                    loadMain     = 1'b1;
                    mainFromSkid = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // in_ready is registered from the next state; it stays low during reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SKID_EMPTY;
            inReady_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inReady_q <= (state_d != SKID_TWO);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mainData_q <= '0;
            mainErr_q  <= 1'b0;
            skidData_q <= '0;
            skidErr_q  <= 1'b0;
        end else begin
            if (loadMain) begin
                mainData_q <= mainFromSkid ? skidData_q : laneData;
                mainErr_q  <= mainFromSkid ? skidErr_q  : laneErr;
            end
            if (loadSkid) begin
                skidData_q <= laneData;
                skidErr_q  <= laneErr;
            end
        end
    end

endmodule

// File: tb/tb_load_ext_pipe.sv
// Directed self-checking bench for load_ext_pipe (32-bit and 64-bit instances).
// Expected values for the misalignment case follow LOAD_EXT_MISALIGN_TRAP_EN.
module tb_load_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        inValid, inReady, inSext, outValid, outReady, outErr;
    logic [31:0] inData, outData;
    logic [1:0]  inOff, inSize;

    logic        inValid64, inReady64, inSext64, outValid64, outReady64, outErr64;
    logic [63:0] inData64, outData64;
    logic [2:0]  inOff64;
    logic [1:0]  inSize64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_ext_pipe #(.DATA_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(inValid), .in_ready_o(inReady), .in_data_i(inData),
        .in_off_i(inOff), .in_size_i(inSize), .in_sext_i(inSext),
        .out_valid_o(outValid), .out_ready_i(outReady),
        .out_data_o(outData), .out_err_o(outErr)
    );

    load_ext_pipe #(.DATA_W(64)) dut64 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(inValid64), .in_ready_o(inReady64), .in_data_i(inData64),
        .in_off_i(inOff64), .in_size_i(inSize64), .in_sext_i(inSext64),
        .out_valid_o(outValid64), .out_ready_i(outReady64),
        .out_data_o(outData64), .out_err_o(outErr64)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [1:0] off,
                                 input logic [1:0] sz, input logic sx);
        inValid = 1'b1;
        inData  = d;
        inOff   = off;
        inSize  = sz;
        inSext  = sx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        inValid = 1'b0; inData = '0; inOff = '0; inSize = '0; inSext = 1'b0; outReady = 1'b1;
        inValid64 = 1'b0; inData64 = '0; inOff64 = '0; inSize64 = '0; inSext64 = 1'b0; outReady64 = 1'b1;

        #12;
        checkOutput("reset out_valid", 64'(outValid), 64'd0);
        checkOutput("reset out_data",  64'(outData),  64'd0);
        checkOutput("reset out_err",   64'(outErr),   64'd0);
        checkOutput("reset in_ready",  64'(inReady),  64'd0);
        #11;
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready before first edge", 64'(inReady), 64'd0);
        tick();
        checkOutput("in_ready after reset", 64'(inReady), 64'd1);

        // Byte at offset 3, sign-extended
        applyStimulus(32'h80F1_7F22, 2'd3, 2'b00, 1'b1);
        tick();
        inValid = 1'b0;
        checkOutput("t1 valid", 64'(outValid), 64'd1);
        checkOutput("t1 byte sext", 64'(outData), 64'h0000_0000_FFFF_FF80);
        tick();
        checkOutput("t1 popped", 64'(outValid), 64'd0);

        // Half at offset 2, zero then sign extension, back to back
        applyStimulus(32'h80F1_7F22, 2'd2, 2'b01, 1'b0);
        tick();
        checkOutput("t2 half zext", 64'(outData), 64'h0000_0000_0000_80F1);
        applyStimulus(32'h80F1_7F22, 2'd2, 2'b01, 1'b1);
        tick();
        checkOutput("t2 half sext", 64'(outData), 64'h0000_0000_FFFF_80F1);
        checkOutput("t2 throughput valid", 64'(outValid), 64'd1);
        applyStimulus(32'h80F1_7F22, 2'd1, 2'b00, 1'b1);
        tick();
        checkOutput("byte off1 positive", 64'(outData), 64'h0000_0000_0000_007F);
        applyStimulus(32'h80F1_7F22, 2'd0, 2'b10, 1'b1);
        tick();
        checkOutput("word full width", 64'(outData), 64'h0000_0000_80F1_7F22);
        applyStimulus(32'h80F1_7F22, 2'd0, 2'b11, 1'b0);
        tick();
        checkOutput("size11 as word", 64'(outData), 64'h0000_0000_80F1_7F22);

        // Misaligned half
        applyStimulus(32'h80F1_7F22, 2'd1, 2'b01, 1'b0);
        tick();
        inValid = 1'b0;
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
        checkOutput("t4 err", 64'(outErr), 64'd1);
        checkOutput("t4 data", 64'(outData), 64'd0);
`else
        checkOutput("t4 err", 64'(outErr), 64'd0);
        checkOutput("t4 data", 64'(outData), 64'h0000_0000_0000_7F22);
`endif
        tick();
        checkOutput("t4 drained", 64'(outValid), 64'd0);

        // Stall with three back-to-back pushes
        outReady = 1'b0;
        applyStimulus(32'h0000_0011, 2'd0, 2'b00, 1'b0);
        tick();
        checkOutput("t3 ready after one", 64'(inReady), 64'd1);
        applyStimulus(32'h0000_0022, 2'd0, 2'b00, 1'b0);
        tick();
        checkOutput("t3 ready full", 64'(inReady), 64'd0);
        applyStimulus(32'h0000_0033, 2'd0, 2'b00, 1'b0);
        tick();
        checkOutput("t3 still full", 64'(inReady), 64'd0);
        checkOutput("t3 stable head", 64'(outData), 64'h11);
        checkOutput("t3 head valid", 64'(outValid), 64'd1);
        outReady = 1'b1;
        tick();
        checkOutput("t3 second", 64'(outData), 64'h22);
        checkOutput("t3 ready back", 64'(inReady), 64'd1);
        tick();
        inValid = 1'b0;
        checkOutput("t3 third", 64'(outData), 64'h33);
        checkOutput("t3 third valid", 64'(outValid), 64'd1);
        tick();
        checkOutput("t3 empty", 64'(outValid), 64'd0);

        // Reset while two results are held
        outReady = 1'b0;
        applyStimulus(32'h0000_0044, 2'd0, 2'b00, 1'b0);
        tick();
        applyStimulus(32'h0000_0055, 2'd0, 2'b00, 1'b0);
        tick();
        inValid = 1'b0;
        checkOutput("t6 full before reset", 64'(inReady), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6 valid in reset", 64'(outValid), 64'd0);
        checkOutput("t6 data in reset", 64'(outData), 64'd0);
        outReady = 1'b1;
        #4;
        rst_n = 1'b1;
        tick();
        checkOutput("t6 no stale 1", 64'(outValid), 64'd0);
        tick();
        checkOutput("t6 no stale 2", 64'(outValid), 64'd0);
        checkOutput("t6 ready restored", 64'(inReady), 64'd1);

        // 64-bit instance: word at offset 4 sign-extended, then full doubleword
        inValid64 = 1'b1; inData64 = 64'h8000_0000_0000_0001;
        inOff64 = 3'd4; inSize64 = 2'b10; inSext64 = 1'b1;
        tick();
        checkOutput("t5 w64 sext", outData64, 64'hFFFF_FFFF_8000_0000);
        inOff64 = 3'd0; inSize64 = 2'b11; inSext64 = 1'b1;
        tick();
        checkOutput("t5 dword", outData64, 64'h8000_0000_0000_0001);
        inOff64 = 3'd6; inSize64 = 2'b01; inSext64 = 1'b0; inData64 = 64'h1234_5678_9ABC_DEF0;
        tick();
        inValid64 = 1'b0;
        checkOutput("t5 half off6", outData64, 64'h0000_0000_0000_1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
